// File: rtl/rf_wb_scheduler.sv
// Register-file writeback arbiter: pipeline writes win, multi-cycle results queue in a
// 2-entry FIFO, and a busy scoreboard plus starvation guard drive the decode stall.
module rf_wb_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_rd_index,
  input  logic [31:0] pipe_wb_data,
  input  logic        mu_valid,
  input  logic [4:0]  mu_rd_index,
  input  logic [31:0] mu_data,
  output logic        mu_ready,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd_index,
  input  logic        id_valid,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  input  logic        id_rd_en,
  input  logic [4:0]  id_rd_index,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  rd_index,
  output logic [31:0] wb_data,
  output logic [31:0] busy_mask
);

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned STARVE_W   = 3;
  localparam int unsigned STARVE_LIM = 4;

  logic [4:0]          rd_q   [DEPTH];
  logic [31:0]         data_q [DEPTH];
  logic                head_q, head_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                hold_q, hold_d;
  logic [31:0]         busy_q, busy_d;
  logic                push, pop, tail;
  logic                fifo_empty;

  assign fifo_empty = (count_q == CNT_W'(0));
  assign mu_ready   = (count_q < CNT_W'(DEPTH));
  assign push       = mu_valid && mu_ready;
  assign pop        = !pipe_wb_en && !fifo_empty;
  assign tail       = head_q ^ count_q[0];
  assign busy_mask  = busy_q;

  // Write port mux: pipeline first, then FIFO head, otherwise idle zeros.
  always_comb begin
    wb_en    = 1'b0;
    rd_index = 5'd0;
    wb_data  = 32'd0;
    if (pipe_wb_en) begin
      wb_en    = (pipe_rd_index != 5'd0);
      rd_index = pipe_rd_index;
      wb_data  = pipe_wb_data;
    end else if (!fifo_empty) begin
      wb_en    = (rd_q[head_q] != 5'd0);
      rd_index = rd_q[head_q];
      wb_data  = data_q[head_q];
    end
  end

  always_comb begin
    stall = hold_q || (id_valid && (busy_q[rs1_index] || busy_q[rs2_index] ||
                                    (id_rd_en && busy_q[id_rd_index])));
  end

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Starvation guard: count pipeline-occupied cycles while a result waits.
    starve_d = starve_q;
    hold_d   = hold_q;
    if (pop || fifo_empty) begin
      starve_d = STARVE_W'(0);
      hold_d   = 1'b0;
    end else begin
      if (pipe_wb_en && (starve_q != STARVE_W'(STARVE_LIM))) starve_d = starve_q + STARVE_W'(1);
      if (starve_d == STARVE_W'(STARVE_LIM)) hold_d = 1'b1;
    end

    // A same-edge set overrides the clear.
    busy_d = busy_q;
    if (pop && (rd_q[head_q] != 5'd0)) busy_d[rd_q[head_q]] = 1'b0;
    if (issue_en && (issue_rd_index != 5'd0)) busy_d[issue_rd_index] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= 1'b0;
      count_q  <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      busy_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      if (push) begin
        rd_q[tail]   <= mu_rd_index;
        data_q[tail] <= mu_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with hand-computed expectations.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_rd_index;
  logic [31:0] pipe_wb_data;
  logic        mu_valid;
  logic [4:0]  mu_rd_index;
  logic [31:0] mu_data;
  logic        mu_ready;
  logic        issue_en;
  logic [4:0]  issue_rd_index;
  logic        id_valid;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic        id_rd_en;
  logic [4:0]  id_rd_index;
  logic        stall;
  logic        wb_en;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_rd_index(pipe_rd_index), .pipe_wb_data(pipe_wb_data),
    .mu_valid(mu_valid), .mu_rd_index(mu_rd_index), .mu_data(mu_data), .mu_ready(mu_ready),
    .issue_en(issue_en), .issue_rd_index(issue_rd_index),
    .id_valid(id_valid), .rs1_index(rs1_index), .rs2_index(rs2_index),
    .id_rd_en(id_rd_en), .id_rd_index(id_rd_index),
    .stall(stall), .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_en"}, 32'(wb_en), 32'(en));
    chk({tag, "_rd"}, 32'(rd_index), 32'(rd));
    chk({tag, "_data"}, wb_data, d);
  endtask

  initial begin
    rst = 1'b1;
    pipe_wb_en = 1'b0; pipe_rd_index = '0; pipe_wb_data = '0;
    mu_valid = 1'b0; mu_rd_index = '0; mu_data = '0;
    issue_en = 1'b0; issue_rd_index = '0;
    id_valid = 1'b0; rs1_index = '0; rs2_index = '0; id_rd_en = 1'b0; id_rd_index = '0;
    #2;
    chk("rst_mu_ready", 32'(mu_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk_wb("rst_wb", 1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b0;

    // Basic latency and busy clear
    issue_en = 1'b1; issue_rd_index = 5'd5;
    step();
    issue_en = 1'b0;
    chk("lat_busy_set", busy_mask, 32'h0000_0020);
    mu_valid = 1'b1; mu_rd_index = 5'd5; mu_data = 32'hDEAD_BEEF;
    #1 chk("lat_pre_wb_en", 32'(wb_en), 32'd0);
    step();
    mu_valid = 1'b0;
    #1 chk_wb("lat_wb", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("lat_busy_held", busy_mask, 32'h0000_0020);
    step();
    chk("lat_busy_clr", busy_mask, 32'd0);
    chk_wb("lat_idle", 1'b0, 5'd0, 32'd0);

    // Scoreboard stall on rs2
    issue_en = 1'b1; issue_rd_index = 5'd7;
    step();
    issue_en = 1'b0;
    id_valid = 1'b1; rs1_index = 5'd3; rs2_index = 5'd7;
    #1 chk("sb_stall0", 32'(stall), 32'd1);
    mu_valid = 1'b1; mu_rd_index = 5'd7; mu_data = 32'h0000_0077;
    pipe_wb_en = 1'b1; pipe_rd_index = 5'd2; pipe_wb_data = 32'h0000_1234;
    #1 chk("sb_stall1", 32'(stall), 32'd1);
    chk_wb("sb_pipe", 1'b1, 5'd2, 32'h0000_1234);
    step();
    mu_valid = 1'b0; pipe_wb_en = 1'b0;
    #1 chk("sb_stall2", 32'(stall), 32'd1);
    chk_wb("sb_head", 1'b1, 5'd7, 32'h0000_0077);
    step();
    chk("sb_stall_clr", 32'(stall), 32'd0);
    chk("sb_busy_clr", busy_mask, 32'd0);
    id_valid = 1'b0;

    // Starvation guard
    mu_valid = 1'b1; mu_rd_index = 5'd10; mu_data = 32'h0000_00AA;
    step();
    mu_valid = 1'b0;
    pipe_wb_en = 1'b1; pipe_rd_index = 5'd1; pipe_wb_data = 32'h0000_0011;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("stv_nostall_c%0d", i + 1), 32'(stall), 32'd0);
      chk_wb($sformatf("stv_pipe_c%0d", i + 1), 1'b1, 5'd1, 32'h0000_0011);
      step();
    end
    pipe_wb_en = 1'b0;
    #1 chk("stv_stall_c5", 32'(stall), 32'd1);
    chk_wb("stv_head_c5", 1'b1, 5'd10, 32'h0000_00AA);
    step();
    chk("stv_stall_rel", 32'(stall), 32'd0);
    chk_wb("stv_idle", 1'b0, 5'd0, 32'd0);

    // FIFO full, back-pressure, ordering and simultaneous push/pop
    pipe_wb_en = 1'b1; pipe_rd_index = 5'd3; pipe_wb_data = 32'h0000_0033;
    mu_valid = 1'b1; mu_rd_index = 5'd11; mu_data = 32'h0000_00B1;
    #1 chk("ff_ready0", 32'(mu_ready), 32'd1);
    step();
    mu_rd_index = 5'd12; mu_data = 32'h0000_00B2;
    #1 chk("ff_ready1", 32'(mu_ready), 32'd1);
    step();
    mu_rd_index = 5'd13; mu_data = 32'h0000_00B3;
    #1 chk("ff_full", 32'(mu_ready), 32'd0);
    step();
    chk("ff_full_wait", 32'(mu_ready), 32'd0);
    pipe_wb_en = 1'b0;
    #1 chk_wb("ff_pop1", 1'b1, 5'd11, 32'h0000_00B1);
    chk("ff_ready_pop1", 32'(mu_ready), 32'd0);
    step();
    chk_wb("ff_pop2", 1'b1, 5'd12, 32'h0000_00B2);
    chk("ff_ready_pop2", 32'(mu_ready), 32'd1);
    step();
    mu_valid = 1'b0;
    #1 chk_wb("ff_pop3", 1'b1, 5'd13, 32'h0000_00B3);
    step();
    chk_wb("ff_empty", 1'b0, 5'd0, 32'd0);

    // Result to r0 writes nothing and leaves scoreboard alone
    issue_en = 1'b1; issue_rd_index = 5'd4;
    step();
    issue_en = 1'b0;
    mu_valid = 1'b1; mu_rd_index = 5'd0; mu_data = 32'h0000_0055;
    step();
    mu_valid = 1'b0;
    #1 chk_wb("r0_head", 1'b0, 5'd0, 32'h0000_0055);
    step();
    chk("r0_busy", busy_mask, 32'h0000_0010);
    chk_wb("r0_idle", 1'b0, 5'd0, 32'd0);

    // Same-edge set and clear of r9: set wins; issue to r0 ignored
    issue_en = 1'b1; issue_rd_index = 5'd9;
    mu_valid = 1'b1; mu_rd_index = 5'd9; mu_data = 32'h0000_0099;
    step();
    mu_valid = 1'b0;
    chk("sc_busy_set", busy_mask, 32'h0000_0210);
    #1 chk_wb("sc_head", 1'b1, 5'd9, 32'h0000_0099);
    step();
    chk("sc_set_wins", busy_mask, 32'h0000_0210);
    issue_rd_index = 5'd0;
    step();
    issue_en = 1'b0;
    chk("r0_never_busy", busy_mask, 32'h0000_0210);

    // Mid-operation reset discards buffered result
    pipe_wb_en = 1'b1; pipe_rd_index = 5'd8; pipe_wb_data = 32'h0000_0088;
    mu_valid = 1'b1; mu_rd_index = 5'd6; mu_data = 32'h0000_0066;
    step();
    mu_valid = 1'b0; pipe_wb_en = 1'b0;
    #1 chk_wb("mr_head", 1'b1, 5'd6, 32'h0000_0066);
    rst = 1'b1;
    #1;
    chk_wb("mr_rst_wb", 1'b0, 5'd0, 32'd0);
    chk("mr_rst_busy", busy_mask, 32'd0);
    chk("mr_rst_ready", 32'(mu_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    chk_wb("mr_discard", 1'b0, 5'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 SHALL have port pipe_wb_en, input, 1 bit: pipeline writeback request, this cycle only, never back-pressured.
REQ-004 SHALL have port pipe_rd_index, input, 5 bits: pipeline destination register.
REQ-005 SHALL have port pipe_wb_data, input, 32 bits: pipeline writeback data.
REQ-006 SHALL have port mu_valid, input, 1 bit: multi-cycle unit result valid.
REQ-007 SHALL have port mu_rd_index, input, 5 bits: multi-cycle unit destination register.
REQ-008 SHALL have port mu_data, input, 32 bits: multi-cycle unit result data.
REQ-009 SHALL have port mu_ready, output, 1 bit: result accepted when mu_valid&&mu_ready at a rising edge.
REQ-010 SHALL have port issue_en, input, 1 bit: multi-cycle op issued this cycle.
REQ-011 SHALL have port issue_rd_index, input, 5 bits: destination of the issued multi-cycle op.
REQ-012 SHALL have port id_valid, input, 1 bit: decode holds a valid instruction.
REQ-013 SHALL have ports rs1_index and rs2_index, input, 5 bits each: decode source registers.
REQ-014 SHALL have ports id_rd_en (1 bit) and id_rd_index (5 bits), input: decode destination register.
REQ-015 SHALL have port stall, output, 1 bit: decode must hold.
REQ-016 SHALL have ports wb_en (1 bit), rd_index (5 bits) and wb_data (32 bits), output: register-file write port.
REQ-017 SHALL have port busy_mask, output, 32 bits: scoreboard, bit 0 constant 0.

Function
REQ-018 SHALL buffer multi-cycle results in a 2-entry FIFO (rd_index + data per entry) with count 0..2.
REQ-019 SHALL drive mu_ready = (count < 2), from registered state only.
REQ-020 SHALL push the FIFO at a rising edge when mu_valid&&mu_ready.
REQ-021 SHALL, in any cycle with pipe_wb_en=1, combinationally drive wb_en=(pipe_rd_index!=0), rd_index=pipe_rd_index, wb_data=pipe_wb_data, and SHALL NOT pop the FIFO.
REQ-022 SHALL, with pipe_wb_en=0 and count>0, drive the FIFO head onto the port with wb_en=(head rd!=0), and pop at the next edge.
REQ-023 SHALL drive wb_en=0, rd_index=0 and wb_data=0 when neither source drives the port.
REQ-024 SHALL give an accepted result a minimum latency of one cycle: pushed at edge N, presented in cycle N..N+1, written by the register file at edge N+1.
REQ-025 SHALL allow push and pop at the same edge, leaving count unchanged and preserving order.
REQ-026 SHALL count consecutive cycles in which count>0 and pipe_wb_en=1 in a 3-bit starve counter, reset to 0 on any pop or when count=0.
REQ-027 SHALL assert starve_hold when the starve counter reaches 4, and keep it until the head is popped.
REQ-028 SHALL set busy_mask[issue_rd_index] at the edge where issue_en=1 and issue_rd_index!=0.
REQ-029 SHALL clear busy_mask[r] at the edge where a FIFO entry with rd=r (r!=0) is popped.
REQ-030 SHALL, when a set and a clear hit the same register at the same edge, make the set win.
REQ-031 SHALL drive stall = starve_hold || (id_valid && (busy[rs1_index] || busy[rs2_index] || (id_rd_en && busy[id_rd_index]))), combinationally.
REQ-032 SHALL never report register 0 as busy.

Reset
REQ-033 SHALL, while rst=1 and independent of clk, set count=0, starve counter=0, starve_hold=0 and busy_mask=0.
REQ-034 SHALL therefore drive mu_ready=1, wb_en=0 and stall=0 during reset.
REQ-035 SHALL discard, on a reset asserted mid-operation, any buffered result, writing nothing for it.

Verification
REQ-036 SHALL pass: issue_en, rd=5; later mu_valid, rd=5, data=0xDEADBEEF, with no pipe writes -> wb_en=1, rd_index=5, wb_data=0xDEADBEEF in the following cycle; busy_mask[5] clears after that edge.
REQ-037 SHALL pass: busy[7]=1 and id_valid, rs2_index=7 -> stall=1 until the rd=7 result pops; stall=0 in the cycle after.
REQ-038 SHALL pass: pipe_wb_en held high 4 cycles with FIFO holding one entry -> stall=1 from cycle 5; the entry writes in the first cycle with pipe_wb_en=0.
REQ-039 SHALL pass: two results accepted back-to-back with pipe_wb_en=1 -> mu_ready=0 with count=2; a third mu_valid waits; entries write in FIFO order.
REQ-040 SHALL pass: mu result with rd=0 -> popped with wb_en=0 and busy_mask unchanged.
REQ-041 SHALL pass: issue rd=9 at the same edge as popping rd=9 -> busy_mask[9]=1 afterwards.
